// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM sequencer that drives the external coprocessor ALU.
// Holds the FSM state encoding, ALU opcodes and mode values.
package gcd_lcm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        CMP  = 3'd2,
        LT   = 3'd3,
        UPD  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_LCM = 1'b1;

    localparam int ALU_W = 32;

    // States in which an operation is in flight and new commands are refused.
    function automatic logic is_busy_state(input state_t s);
        case (s)
            CHK, CMP, LT, UPD: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gcd_lcm_seq.sv
// Iterative GCD (repeated subtraction) / LCM (repeated addition) sequencer driving a sibling ALU.
// Optional macro GCD_LCM_ITER_CNT_EN exposes the final iteration count on port iter_cnt.
module gcd_lcm_seq
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [ALU_W-1:0] alu_y,
    input  logic             alu_z
`ifdef GCD_LCM_ITER_CNT_EN
    ,
    output logic [15:0]      iter_cnt
`endif
);

    localparam int ITER_W = $clog2(MAX_ITER + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_x, r_y, r_a0, r_b0, r_result;
    logic [WIDTH-1:0]    w_x_nxt, w_y_nxt, w_a0_nxt, w_b0_nxt, w_result_nxt;
    logic                r_mode, r_lt, r_busy, r_done, r_err;
    logic                w_mode_nxt, w_lt_nxt, w_done_nxt, w_err_nxt;
    logic [ITER_W-1:0]   r_iter;
    logic [ITER_W-1:0]   w_iter_nxt;
    logic [ALU_W-1:0]    w_alu_a, w_alu_b;
    logic [2:0]          w_alu_op;
    logic [WIDTH-1:0]    w_alu_res;

    assign w_alu_res = WIDTH'(alu_y);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath next values and ALU drive.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_a0_nxt     = r_a0;
        w_b0_nxt     = r_b0;
        w_mode_nxt   = r_mode;
        w_lt_nxt     = r_lt;
        w_iter_nxt   = r_iter;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        w_result_nxt = r_result;
        w_alu_a      = {ALU_W{1'b0}};
        w_alu_b      = {ALU_W{1'b0}};
        w_alu_op     = ALU_SUB;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_x_nxt     = opa;
                    w_a0_nxt    = opa;
                    w_y_nxt     = opb;
                    w_b0_nxt    = opb;
                    w_mode_nxt  = mode;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_iter_nxt  = {ITER_W{1'b0}};
                    w_state_nxt = CHK;
                end else begin
                    w_state_nxt = r_state;
                end
            end

            CHK: begin
                if ((r_a0 == {WIDTH{1'b0}}) || (r_b0 == {WIDTH{1'b0}})) begin
                    w_result_nxt = (r_mode == MODE_GCD) ? (r_a0 | r_b0) : {WIDTH{1'b0}};
                    w_err_nxt    = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_state_nxt  = CMP;
                end
            end

            CMP: begin
                w_alu_a  = ALU_W'(r_x);
                w_alu_b  = ALU_W'(r_y);
                w_alu_op = ALU_SUB;
                if (alu_z) begin
                    w_result_nxt = r_x;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_state_nxt  = LT;
                end
            end

            LT: begin
                w_alu_a     = ALU_W'(r_x);
                w_alu_b     = ALU_W'(r_y);
                w_alu_op    = ALU_SLT;
                w_lt_nxt    = alu_y[0];
                w_state_nxt = UPD;
            end

            UPD: begin
                // GCD subtracts smaller from larger; LCM advances the smaller running multiple.
                if (r_mode == MODE_GCD) begin
                    w_alu_op = ALU_SUB;
                    if (r_lt) begin
                        w_alu_a = ALU_W'(r_y);
                        w_alu_b = ALU_W'(r_x);
                    end else begin
                        w_alu_a = ALU_W'(r_x);
                        w_alu_b = ALU_W'(r_y);
                    end
                end else begin
                    w_alu_op = ALU_ADD;
                    if (r_lt) begin
                        w_alu_a = ALU_W'(r_x);
                        w_alu_b = ALU_W'(r_a0);
                    end else begin
                        w_alu_a = ALU_W'(r_y);
                        w_alu_b = ALU_W'(r_b0);
                    end
                end

                if (r_iter == ITER_W'(MAX_ITER)) begin
                    w_err_nxt    = 1'b1;
                    w_result_nxt = {WIDTH{1'b0}};
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = DONE;
                end else if ((r_mode == MODE_LCM) && (alu_y < w_alu_a)) begin
                    w_iter_nxt   = r_iter + ITER_W'(1'b1);
                    w_err_nxt    = 1'b1;
                    w_result_nxt = {WIDTH{1'b0}};
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_iter_nxt  = r_iter + ITER_W'(1'b1);
                    w_state_nxt = CMP;
                    if ((r_mode == MODE_GCD) != r_lt) begin
                        w_x_nxt = w_alu_res;
                    end else begin
                        w_y_nxt = w_alu_res;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= {WIDTH{1'b0}};
            r_y      <= {WIDTH{1'b0}};
            r_a0     <= {WIDTH{1'b0}};
            r_b0     <= {WIDTH{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_mode   <= MODE_GCD;
            r_lt     <= 1'b0;
            r_iter   <= {ITER_W{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_a0     <= w_a0_nxt;
            r_b0     <= w_b0_nxt;
            r_result <= w_result_nxt;
            r_mode   <= w_mode_nxt;
            r_lt     <= w_lt_nxt;
            r_iter   <= w_iter_nxt;
            r_busy   <= is_busy_state(w_state_nxt);
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;
    assign alu_a  = w_alu_a;
    assign alu_b  = w_alu_b;
    assign alu_op = w_alu_op;

`ifdef GCD_LCM_ITER_CNT_EN
    assign iter_cnt = 16'(r_iter);
`endif

endmodule
